alu_share_arbiter: RTL

Shares the single combinational 64-bit ALU (add/sub/and/xor, 2-bit function select, signed-overflow flag) between two requesters, e.g. the execute stage and an address-generation unit. Round-robin arbitration with valid/ready handshakes on each request port and on the response port. The block drives the ALU operand and select lines and waits a configurable settle time. It returns a registered result tagged with the requester ID, plus Y86-64 condition flags (ZF, SF, OF).

---
 rtl/alu_share_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational 64-bit ALU between two
//            requesters. Each accepted request is held on the ALU inputs for
//            EXEC_CYCLES cycles. The block then returns a registered,
//            ID-tagged result with Y86-64 style ZF/SF/OF flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W      = 64,
  parameter int EXEC_CYCLES = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  // request side
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req0_fn,
  input  logic [1:0]        req1_fn,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_s1,
  output logic              alu_s0,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovf,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zf,
  output logic              rsp_sf,
  output logic              rsp_of,
  output logic              busy
);

  // A 4-bit counter covers the full legal EXEC_CYCLES range of 1..15.
  localparam int                CNT_W     = 4;
  localparam logic [CNT_W-1:0]  EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [1:0]          fn_q, fn_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zf_q, zf_d;
  logic                sf_q, sf_d;
  logic                of_q, of_d;

  logic [1:0]          grant_w;
  logic                hs_w;
  logic                gid_w;

  // Round-robin pick among valid requesters; on a tie, the one not served last wins.
  always_comb begin
    grant_w = 2'b00;
    unique case (req_valid)
      2'b01:   grant_w = 2'b01;
      2'b10:   grant_w = 2'b10;
      2'b11:   grant_w = rr_last_q ? 2'b01 : 2'b10;
      default: grant_w = 2'b00;
    endcase
  end

  // Grants are offered only while idle and never while reset is asserted.
  assign req_ready = ((state_q == S_IDLE) && !reset) ? grant_w : 2'b00;
  assign hs_w      = |(req_valid & req_ready);
  assign gid_w     = req_ready[1];

  // Next-state and datapath update for the IDLE -> EXEC -> RESP transaction.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    fn_d      = fn_q;
    id_d      = id_q;
    res_d     = res_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs_w) begin
          a_d       = gid_w ? req1_a  : req0_a;
          b_d       = gid_w ? req1_b  : req0_b;
          fn_d      = gid_w ? req1_fn : req0_fn;
          id_d      = gid_w;
          rr_last_d = gid_w;
          cnt_d     = EXEC_LOAD;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_out;
          zf_d    = (alu_out == '0);
          sf_d    = alu_out[DATA_W-1];
          // Overflow is meaningful only for add/sub (fn[1] == 0).
          of_d    = alu_ovf & ~fn_q[1];
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fn_q      <= 2'b00;
      id_q      <= 1'b0;
      res_q     <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      fn_q      <= fn_d;
      id_q      <= id_d;
      res_q     <= res_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_s1     = fn_q[1];
  assign alu_s0     = fn_q[0];
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zf     = zf_q;
  assign rsp_sf     = sf_q;
  assign rsp_of     = of_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
